// File: rtl/wb_clint.sv
// ---------------------------------------------------------------------------
// wb_clint - machine-level core-local interruptor behind a Wishbone B4
//            classic slave port (one instance per hart).
//
// Holds the 64-bit free-running mtime counter, the 64-bit mtimecmp compare
// value and the msip software-interrupt bit. It raises the timer and
// software interrupt lines for the core.
//
// Parameters
//   ADDR_WIDTH  low address bits decoded (upper bits belong to the interconnect)
//   TICK_DIV    clk_i cycles per mtime increment, 1..65535
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_i        asynchronous active-low reset
//   wbs_cyc_i    bus cycle valid
//   wbs_stb_i    strobe (request = cyc & stb)
//   wbs_we_i     1 = write, 0 = read
//   wbs_sel_i    byte enables for writes
//   wbs_addr_i   byte address
//   wbs_dat_i    write data
//   wbs_dat_o    read data, valid while wbs_ack_o is high, 0 otherwise
//   wbs_ack_o    normal termination, one-cycle pulse
//   wbs_err_o    error termination for unmapped or misaligned words
//   xint_mtip_o  timer interrupt pending   (mtime >= mtimecmp, registered)
//   xint_msip_o  software interrupt pending (msip bit 0)
//
// Register map (offset = addr[ADDR_WIDTH-1:0])
//   0x0000 msip          bit0 R/W, others read 0
//   0x4000 mtimecmp lo   0x4004 mtimecmp hi
//   0xBFF8 mtime lo      0xBFFC mtime hi
// ---------------------------------------------------------------------------
module wb_clint #(
    parameter int ADDR_WIDTH = 16,
    parameter int TICK_DIV   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_addr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        wbs_err_o,
    output logic        xint_mtip_o,
    output logic        xint_msip_o
);

    // Full byte offsets including addr[1:0]; a misaligned address can never
    // match one of these, so it falls through to the error response.
    localparam logic [ADDR_WIDTH-1:0] OFF_MSIP   = ADDR_WIDTH'(16'h0000);
    localparam logic [ADDR_WIDTH-1:0] OFF_CMP_LO = ADDR_WIDTH'(16'h4000);
    localparam logic [ADDR_WIDTH-1:0] OFF_CMP_HI = ADDR_WIDTH'(16'h4004);
    localparam logic [ADDR_WIDTH-1:0] OFF_TIM_LO = ADDR_WIDTH'(16'hBFF8);
    localparam logic [ADDR_WIDTH-1:0] OFF_TIM_HI = ADDR_WIDTH'(16'hBFFC);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t      r_state;
    logic        r_ack;
    logic        r_err;
    logic [31:0] r_dat;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic        r_mtip;
    logic [15:0] r_presc;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_t      w_state_next;
    logic        w_ack_next;
    logic        w_err_next;
    logic [31:0] w_dat_next;
    logic [63:0] w_mtime_next;
    logic [63:0] w_mtimecmp_next;
    logic        w_msip_next;

    logic [ADDR_WIDTH-1:0] w_off;
    logic        w_req;
    logic        w_accept;
    logic        w_wr;
    logic        w_hit_msip;
    logic        w_hit_cmp_lo;
    logic        w_hit_cmp_hi;
    logic        w_hit_tim_lo;
    logic        w_hit_tim_hi;
    logic        w_hit;
    logic [31:0] w_bmask;
    logic [31:0] w_rdata;
    logic        w_tick;
    logic        w_unused_addr;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_off         = wbs_addr_i[ADDR_WIDTH-1:0];
    assign w_unused_addr = ^wbs_addr_i[31:ADDR_WIDTH];

    assign w_req    = wbs_cyc_i & wbs_stb_i;
    assign w_accept = (r_state == ST_IDLE) & w_req;
    assign w_wr     = w_accept & wbs_we_i;

    assign w_hit_msip   = (w_off == OFF_MSIP);
    assign w_hit_cmp_lo = (w_off == OFF_CMP_LO);
    assign w_hit_cmp_hi = (w_off == OFF_CMP_HI);
    assign w_hit_tim_lo = (w_off == OFF_TIM_LO);
    assign w_hit_tim_hi = (w_off == OFF_TIM_HI);
    assign w_hit        = w_hit_msip | w_hit_cmp_lo | w_hit_cmp_hi |
                          w_hit_tim_lo | w_hit_tim_hi;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bmask
            assign w_bmask[gi*8 +: 8] = {8{wbs_sel_i[gi]}};
        end
    endgenerate

    always_comb begin
        w_rdata = 32'h0;
        unique case (1'b1)
            w_hit_msip:   w_rdata = {31'h0, r_msip};
            w_hit_cmp_lo: w_rdata = r_mtimecmp[31:0];
            w_hit_cmp_hi: w_rdata = r_mtimecmp[63:32];
            w_hit_tim_lo: w_rdata = r_mtime[31:0];
            w_hit_tim_hi: w_rdata = r_mtime[63:32];
            default:      w_rdata = 32'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake FSM: IDLE -> RESP -> IDLE. RESP always returns to IDLE,
    // so a request held high is served every second cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_ack_next   = 1'b0;
        w_err_next   = 1'b0;
        w_dat_next   = 32'h0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_next = ST_RESP;
                    if (w_hit) begin
                        w_ack_next = 1'b1;
                        w_dat_next = wbs_we_i ? 32'h0 : w_rdata;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register updates. Writes commit on the accept edge (the edge that
    // raises ack). A write to either mtime half suppresses that cycle's
    // tick, so untouched bytes keep their pre-increment value and a low
    // half write never carries upward.
    // ------------------------------------------------------------------
    assign w_tick = (r_presc == PRESC_LAST);

    always_comb begin
        w_mtime_next = r_mtime;
        if (w_wr && w_hit_tim_lo) begin
            w_mtime_next[31:0] = merge_bytes(r_mtime[31:0], wbs_dat_i, w_bmask);
        end else if (w_wr && w_hit_tim_hi) begin
            w_mtime_next[63:32] = merge_bytes(r_mtime[63:32], wbs_dat_i, w_bmask);
        end else if (w_tick) begin
            w_mtime_next = r_mtime + 64'd1;
        end
    end

    always_comb begin
        w_mtimecmp_next = r_mtimecmp;
        if (w_wr && w_hit_cmp_lo) begin
            w_mtimecmp_next[31:0] = merge_bytes(r_mtimecmp[31:0], wbs_dat_i, w_bmask);
        end else if (w_wr && w_hit_cmp_hi) begin
            w_mtimecmp_next[63:32] = merge_bytes(r_mtimecmp[63:32], wbs_dat_i, w_bmask);
        end
    end

    always_comb begin
        w_msip_next = r_msip;
        if (w_wr && w_hit_msip && wbs_sel_i[0]) begin
            w_msip_next = wbs_dat_i[0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_dat      <= 32'h0;
            r_mtime    <= 64'h0;
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_msip     <= 1'b0;
            r_mtip     <= 1'b0;
            r_presc    <= 16'h0;
        end else begin
            r_state    <= w_state_next;
            r_ack      <= w_ack_next;
            r_err      <= w_err_next;
            r_dat      <= w_dat_next;
            r_mtime    <= w_mtime_next;
            r_mtimecmp <= w_mtimecmp_next;
            r_msip     <= w_msip_next;
            // Compares the current register values, so it trails any
            // mtime/mtimecmp update by one cycle.
            r_mtip     <= (r_mtime >= r_mtimecmp);
            r_presc    <= w_tick ? 16'h0 : (r_presc + 16'd1);
        end
    end

    assign wbs_ack_o   = r_ack;
    assign wbs_err_o   = r_err;
    assign wbs_dat_o   = r_dat;
    assign xint_mtip_o = r_mtip;
    assign xint_msip_o = r_msip;

endmodule

// File: tb/tb_wb_clint.sv
// ---------------------------------------------------------------------------
// tb_wb_clint - directed self-checking bench for wb_clint (TICK_DIV = 1).
// Drives inputs on the falling edge, samples 1 ns after the rising edge.
// mtime expectations use the bench's own edge counter: a value written at
// edge W reads back at edge R as written + (R - 1 - W).
// ---------------------------------------------------------------------------
module tb_wb_clint;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [31:0] dat_o;
    logic        ack;
    logic        err;
    logic        mtip;
    logic        msip;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wb_clint #(
        .ADDR_WIDTH (16),
        .TICK_DIV   (1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_addr_i  (addr),
        .wbs_dat_i   (wdat),
        .wbs_dat_o   (dat_o),
        .wbs_ack_o   (ack),
        .wbs_err_o   (err),
        .xint_mtip_o (mtip),
        .xint_msip_o (msip)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    // One bus access. Waits for the slave to be idle, raises the request on a
    // falling edge and waits (bounded) for ack or err. hs encodes the
    // response as latency*4 + ack*2 + err; 0 means no response at all.
    task automatic bus(input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, output logic [31:0] rd,
                       output int hs, output int unsigned ed);
        @(posedge clk);
        @(negedge clk);
        addr = a; we = w; sel = s; wdat = d; cyc = 1'b1; stb = 1'b1;
        hs = 0; rd = 32'h0; ed = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            if (ack || err) begin
                hs = i * 4 + (ack ? 2 : 0) + (err ? 1 : 0);
                rd = dat_o;
                ed = cyc_cnt;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    // Access expected to be acked one cycle after the strobe.
    task automatic acc(input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, input string tag,
                       output logic [31:0] rd, output int unsigned ed);
        int hs;
        bus(a, w, s, d, rd, hs, ed);
        check({tag, "_hs"}, 64'(hs), 64'd6);
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] rd;
        int unsigned ed;
        acc(a, 1'b0, 4'hF, 32'h0, tag, rd, ed);
        check(tag, 64'(rd), 64'(exp));
    endtask

    // Access expected to end in a single err pulse with no data.
    task automatic err_chk(input logic [31:0] a, input logic w, input string tag);
        logic [31:0] rd;
        int hs;
        int unsigned ed;
        bus(a, w, 4'hF, 32'h0, rd, hs, ed);
        check({tag, "_hs"}, 64'(hs), 64'd5);
        check({tag, "_dat"}, 64'(rd), 64'h0);
        @(posedge clk); #1;
        check({tag, "_once"}, 64'({ack, err}), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int unsigned ed;
        int unsigned w_edge;
        int unsigned first;
        int unsigned rel;
        int          n_ack;
        int          n_err;
        logic [63:0] model;
        logic [31:0] lo_pre;

        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; addr = 32'h0; wdat = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", 64'({ack, err, mtip, msip}), 64'h0);
        check("rst_dat", 64'(dat_o), 64'h0);
        @(negedge clk) rst_n = 1'b1;

        // Reset values of mtimecmp
        rd_chk(32'h0000_4004, 32'hFFFF_FFFF, "cmp_hi_rst");
        rd_chk(32'h0000_4000, 32'hFFFF_FFFF, "cmp_lo_rst");
        check("mtip_rst", 64'(mtip), 64'h0);
        @(posedge clk); #1;
        check("dat_idle", 64'(dat_o), 64'h0);

        // Timer interrupt: mtime = 0, mtimecmp = 20
        acc(32'h0000_BFFC, 1'b1, 4'hF, 32'h0, "wr_time_hi", rd, ed);
        acc(32'h0000_BFF8, 1'b1, 4'hF, 32'h0, "wr_time_lo", rd, w_edge);
        acc(32'h0000_4000, 1'b1, 4'hF, 32'd20, "wr_cmp_lo", rd, ed);
        acc(32'h0000_4004, 1'b1, 4'hF, 32'h0, "wr_cmp_hi", rd, ed);
        check("mtip_before", 64'(mtip), 64'h0);
        first = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (mtip && first == 0) first = cyc_cnt;
        end
        // mtime hits 20 at edge w_edge+20, mtip follows one edge later
        check("mtip_rise_edge", 64'(first - w_edge), 64'd21);
        acc(32'h0000_4004, 1'b1, 4'hF, 32'h1, "wr_cmp_hi1", rd, ed);
        check("mtip_lag", 64'(mtip), 64'h1);
        @(posedge clk); #1;
        check("mtip_clear", 64'(mtip), 64'h0);

        // Software interrupt and byte enables on msip
        acc(32'h0000_0000, 1'b1, 4'b0001, 32'h1, "msip_set", rd, ed);
        check("msip_set_o", 64'(msip), 64'h1);
        acc(32'h0000_0000, 1'b1, 4'b0010, 32'h0, "msip_sel1", rd, ed);
        check("msip_sel1_o", 64'(msip), 64'h1);
        acc(32'h0000_0000, 1'b1, 4'b0001, 32'h0, "msip_clr", rd, ed);
        check("msip_clr_o", 64'(msip), 64'h0);
        acc(32'h0000_0000, 1'b1, 4'hF, 32'hFFFF_FFFF, "msip_ones", rd, ed);
        rd_chk(32'h0000_0000, 32'h1, "msip_rd");

        // Partial byte writes on mtimecmp lo (was 0x14), sel=0000 no-op on hi
        acc(32'h0000_4000, 1'b1, 4'b0101, 32'hAABB_CCDD, "cmp_lo_bytes", rd, ed);
        rd_chk(32'h0000_4000, 32'h00BB_00DD, "cmp_lo_bytes_rd");
        acc(32'h0000_4004, 1'b1, 4'b0000, 32'hFFFF_FFFF, "cmp_hi_nosel", rd, ed);
        rd_chk(32'h0000_4004, 32'h1, "cmp_hi_nosel_rd");

        // Carry from low into high half
        acc(32'h0000_BFFC, 1'b1, 4'hF, 32'h0, "wrap_hi", rd, ed);
        acc(32'h0000_BFF8, 1'b1, 4'hF, 32'hFFFF_FFFF, "wrap_lo", rd, w_edge);
        acc(32'h0000_BFFC, 1'b0, 4'hF, 32'h0, "carry_hi", rd, ed);
        model = 64'h0000_0000_FFFF_FFFF + 64'(ed - 1 - w_edge);
        check("carry_hi_val", 64'(rd), 64'(model[63:32]));
        acc(32'h0000_BFF8, 1'b0, 4'hF, 32'h0, "carry_lo", rd, ed);
        model = 64'h0000_0000_FFFF_FFFF + 64'(ed - 1 - w_edge);
        check("carry_lo_val", 64'(rd), 64'(model[31:0]));

        // Full 64-bit wrap to zero
        acc(32'h0000_BFFC, 1'b1, 4'hF, 32'hFFFF_FFFF, "ones_hi", rd, ed);
        acc(32'h0000_BFF8, 1'b1, 4'hF, 32'hFFFF_FFFF, "ones_lo", rd, w_edge);
        acc(32'h0000_BFF8, 1'b0, 4'hF, 32'h0, "wrap0_lo", rd, ed);
        model = 64'hFFFF_FFFF_FFFF_FFFF + 64'(ed - 1 - w_edge);
        check("wrap0_lo_val", 64'(rd), 64'(model[31:0]));
        acc(32'h0000_BFFC, 1'b0, 4'hF, 32'h0, "wrap0_hi", rd, ed);
        model = 64'hFFFF_FFFF_FFFF_FFFF + 64'(ed - 1 - w_edge);
        check("wrap0_hi_val", 64'(rd), 64'(model[63:32]));

        // Write wins over the tick (every cycle ticks here)
        acc(32'h0000_BFFC, 1'b1, 4'hF, 32'h5, "tw_hi", rd, ed);
        acc(32'h0000_BFF8, 1'b1, 4'hF, 32'h1234, "tw_lo", rd, w_edge);
        acc(32'h0000_BFF8, 1'b0, 4'hF, 32'h0, "tw_lo_rd", rd, ed);
        check("tw_lo_val", 64'(rd), 64'(32'h1234 + (ed - 1 - w_edge)));
        acc(32'h0000_BFFC, 1'b0, 4'hF, 32'h0, "tw_hi_rd", rd, ed);
        check("tw_hi_val", 64'(rd), 64'h5);
        // Single-byte write: other bytes keep the pre-increment value
        acc(32'h0000_BFF8, 1'b1, 4'b0001, 32'h0000_00AA, "tw_byte", rd, ed);
        lo_pre = 32'h1234 + (ed - 1 - w_edge);
        w_edge = ed;
        acc(32'h0000_BFF8, 1'b0, 4'hF, 32'h0, "tw_byte_rd", rd, ed);
        check("tw_byte_val", 64'(rd), 64'({lo_pre[31:8], 8'hAA} + (ed - 1 - w_edge)));

        // Unmapped and misaligned words
        err_chk(32'h0000_0008, 1'b0, "err_0008");
        err_chk(32'h0000_4002, 1'b1, "err_4002");
        err_chk(32'h0000_0004, 1'b1, "err_0004");
        rd_chk(32'h0000_4000, 32'h00BB_00DD, "err_cmp_kept");
        check("err_msip_kept", 64'(msip), 64'h1);

        // Request held for 6 cycles: one access every 2 cycles
        @(posedge clk);
        @(negedge clk);
        addr = 32'h0000_4000; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        n_ack = 0; n_err = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack) n_ack++;
            if (err) n_err++;
        end
        cyc = 1'b0; stb = 1'b0;
        check("b2b_acks", 64'(n_ack), 64'd3);
        check("b2b_errs", 64'(n_err), 64'd0);

        // Make mtip high so the reset visibly clears it
        acc(32'h0000_4004, 1'b1, 4'hF, 32'h0, "pre_rst_cmp_hi", rd, ed);
        acc(32'h0000_4000, 1'b1, 4'hF, 32'h0, "pre_rst_cmp_lo", rd, ed);
        @(posedge clk); #1;
        check("pre_rst_mtip", 64'(mtip), 64'h1);

        // Asynchronous reset in the middle of a response
        @(posedge clk);
        @(negedge clk);
        addr = 32'h0000_BFFC; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        check("mid_resp_ack", 64'({ack, dat_o}), 64'({1'b1, 32'h5}));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out", 64'({ack, err, mtip, msip}), 64'h0);
        check("async_rst_dat", 64'(dat_o), 64'h0);
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc_cnt;
        rd_chk(32'h0000_4004, 32'hFFFF_FFFF, "post_rst_cmp_hi");
        acc(32'h0000_BFF8, 1'b0, 4'hF, 32'h0, "post_rst_time", rd, ed);
        check("post_rst_time_val", 64'(rd), 64'(ed - 1 - rel));
        check("post_rst_msip", 64'(msip), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
